// File: rtl/camera_capture_writer.sv
// camera_capture_writer
// Byte-serial RGB565 sensor capture with 4:1 decimation on both axes,
// producing registered frame-buffer write strobes.
// Optional build macro CAPTURE_FRAME_SKIP_EN: capture alternate frames only
// (first frame after reset captured, next skipped, and so on).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset; wait for vsync high before trusting anything
// S_SYNC    | vertical blanking; leaving it starts a fresh frame
// S_CAPTURE | active frame; bytes with href=1 form pixels
module camera_capture_writer #(
    parameter int unsigned IMAGE_SIZE_H = 160,
    parameter int unsigned IMAGE_SIZE_V = 120,
    parameter int unsigned SRC_SIZE_H   = 640,
    parameter int unsigned SRC_SIZE_V   = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [10:0] src_x_q, src_x_d;
    logic [9:0]  src_y_q, src_y_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        href_q, href_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        frame_done_q, frame_done_d;

    logic        active;
    logic        start_frame;
    logic        end_frame;
    logic        in_window;
    logic        store;
    logic [31:0] dst_x;
    logic [31:0] dst_y;

`ifdef CAPTURE_FRAME_SKIP_EN
    // skip_q is the parity of the frame in progress; it starts at 1 so the
    // first SYNC->CAPTURE after reset flips it to 0 and that frame is kept.
    logic skip_q, skip_d;
`endif

    // Next-state, pixel assembly, decimation and write-port computation
    always_comb begin
        state_d      = state_q;
        src_x_d      = src_x_q;
        src_y_d      = src_y_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        // href is only meaningful inside a frame and never while vsync is high
        active      = (state_q == S_CAPTURE) && !vsync;
        start_frame = (state_q == S_SYNC) && !vsync;
        end_frame   = (state_q == S_CAPTURE) && vsync;
        href_d      = active && href;
        frame_done_d = end_frame;

        unique case (state_q)
            S_IDLE:    if (vsync)  state_d = S_SYNC;
            S_SYNC:    if (!vsync) state_d = S_CAPTURE;
            S_CAPTURE: if (vsync)  state_d = S_SYNC;
            default:   state_d = S_IDLE;
        endcase

        dst_x = 32'(src_x_q[10:2]);
        dst_y = 32'(src_y_q[9:2]);
        in_window = (src_x_q[1:0] == 2'b00) && (src_y_q[1:0] == 2'b00) &&
                    (32'(src_x_q) < SRC_SIZE_H) && (32'(src_y_q) < SRC_SIZE_V) &&
                    (dst_x < IMAGE_SIZE_H) && (dst_y < IMAGE_SIZE_V);
        store = in_window;

`ifdef CAPTURE_FRAME_SKIP_EN
        skip_d = skip_q;
        if (start_frame) skip_d = ~skip_q;
        store = in_window && !skip_q;
        if (skip_q) frame_done_d = 1'b0;
`endif

        if (start_frame) begin
            src_x_d = '0;
            src_y_d = '0;
            phase_d = 1'b0;
        end else if (active) begin
            if (href) begin
                if (!phase_q) begin
                    hi_d    = d;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    src_x_d = src_x_q + 11'd1;
                    if (store) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = 16'(dst_y * IMAGE_SIZE_H + dst_x);
                        wr_data_d = {hi_q, d};
                    end
                end
            end else if (href_q) begin
                // end of line: an unpaired trailing byte is simply forgotten
                src_y_d = src_y_q + 10'd1;
                src_x_d = '0;
                phase_d = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_x_q      <= '0;
            src_y_q      <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            href_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_x_q      <= src_x_d;
            src_y_q      <= src_y_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            href_q       <= href_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef CAPTURE_FRAME_SKIP_EN
    // Frame parity register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) skip_q <= 1'b1;
        else        skip_q <= skip_d;
    end
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_camera_capture_writer.sv
// Bench for camera_capture_writer at reduced geometry (64x48 source, 16x12 dest).
module tb_camera_capture_writer;
    localparam int IMG_H = 16;
    localparam int IMG_V = 12;
    localparam int SRC_H = 64;
    localparam int SRC_V = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        frame_done;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];
    int   fd_count = 0;
    int   dbl_wr = 0;
    logic prev_wr = 1'b0;

    // reference model state
    int  model_y = 0;
    bit  model_armed = 0;
    int  model_frames = 0;
    bit  model_capture = 0;
    bit  incr_mode = 0;
    int  pix_base = 0;

    camera_capture_writer #(
        .IMAGE_SIZE_H(IMG_H), .IMAGE_SIZE_V(IMG_V),
        .SRC_SIZE_H(SRC_H),   .SRC_SIZE_V(SRC_V)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // monitor: sample outputs on the falling edge
    always @(negedge clk) begin
        if (wr_en) act_q.push_back({wr_addr, wr_data});
        if (wr_en && prev_wr) dbl_wr++;
        prev_wr = wr_en;
        if (frame_done) fd_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_armed  = 0;
        model_frames = 0;
        model_y      = 0;
    endtask

    // vsync pulse with href noise, then start of active frame
    task automatic frame_begin();
        vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            href = i[0];
            d = 8'($urandom);
            step();
        end
        vsync = 1'b0;
        href = 1'b0;
        step();
        step();
        model_armed = 1;
        model_frames++;
        model_y = 0;
        model_capture = 1;
`ifdef CAPTURE_FRAME_SKIP_EN
        model_capture = (model_frames % 2) == 1;
`endif
    endtask

    // vsync rises together with a stray href byte; vsync left high
    task automatic frame_end();
        vsync = 1'b1;
        href = 1'b1;
        d = 8'($urandom);
        step();
        href = 1'b0;
        step();
        href = 1'b1;
        d = 8'($urandom);
        step();
        href = 1'b0;
        step();
    endtask

    task automatic drive_line(input int nbytes);
        logic [15:0] px[$];
        int npix;
        npix = (nbytes + 1) / 2;
        for (int k = 0; k < npix; k++)
            px.push_back(incr_mode ? 16'(pix_base + k) : 16'($urandom));
        href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            d = i[0] ? px[i/2][7:0] : px[i/2][15:8];
            step();
        end
        href = 1'b0;
        d = 8'($urandom);
        step();
        step();
        for (int x = 0; x < nbytes / 2; x++) begin
            if (model_armed && model_capture && (x % 4 == 0) && (model_y % 4 == 0) &&
                x < SRC_H && model_y < SRC_V && x / 4 < IMG_H && model_y / 4 < IMG_V)
                exp_q.push_back({16'((model_y / 4) * IMG_H + x / 4), px[x]});
        end
        model_y++;
        pix_base += nbytes / 2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        step();
        step();
        n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_mis++; $display("FAIL reset_wr_addr: got %h expected 0000", wr_addr); end
        n_cmp++; if (wr_data !== 16'h0) begin n_mis++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
        n_cmp++; if (frame_done !== 1'b0) begin n_mis++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst_n = 1'b1;
        model_reset();
        // bytes before any vsync must be ignored
        act_q.delete();
        drive_line(16);
        n_cmp++; if (act_q.size() !== 0) begin n_mis++; $display("FAIL reset_idle_writes: got %0d expected 0", act_q.size()); end
    endtask

    task automatic test_first_pixel();
        fd_count = 0;
        frame_begin();
        act_q.delete();
        href = 1'b1;
        d = 8'hF8;
        step();
        n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL first_early_wr_en: got %b expected 0", wr_en); end
        d = 8'h00;
        step();
        n_cmp++; if (wr_en !== 1'b1) begin n_mis++; $display("FAIL first_wr_en: got %b expected 1", wr_en); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_mis++; $display("FAIL first_wr_addr: got %h expected 0000", wr_addr); end
        n_cmp++; if (wr_data !== 16'hF800) begin n_mis++; $display("FAIL first_wr_data: got %h expected f800", wr_data); end
        href = 1'b0;
        d = 8'h5A;
        step();
        n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL first_strobe_width: got %b expected 0", wr_en); end
        n_cmp++; if (wr_data !== 16'hF800) begin n_mis++; $display("FAIL first_hold_data: got %h expected f800", wr_data); end
        step();
        frame_end();
        n_cmp++; if (fd_count !== (model_capture ? 1 : 0)) begin n_mis++; $display("FAIL first_frame_done: got %0d expected %0d", fd_count, model_capture ? 1 : 0); end
    endtask

    task automatic test_full_frame();
        int exp_fd;
        act_q.delete(); exp_q.delete(); fd_count = 0;
        incr_mode = 1; pix_base = 0;
        frame_begin();
        for (int y = 0; y < SRC_V; y++) drive_line(2 * SRC_H);
        exp_fd = model_capture ? 1 : 0;
        frame_end();
        incr_mode = 0;
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL full_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        n_cmp++; if (act_q.size() !== (model_capture ? IMG_H * IMG_V : 0)) begin n_mis++; $display("FAIL full_total: got %0d expected %0d", act_q.size(), IMG_H * IMG_V); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL full_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
        end
        n_cmp++; if (fd_count !== exp_fd) begin n_mis++; $display("FAIL full_frame_done: got %0d expected %0d", fd_count, exp_fd); end
    endtask

    task automatic test_odd_bytes();
        int exp_fd;
        act_q.delete(); exp_q.delete(); fd_count = 0;
        frame_begin();
        drive_line(5);
        for (int y = 1; y < 16; y++) drive_line(int'($urandom_range(1, 40)) | 1);
        exp_fd = model_capture ? 1 : 0;
        frame_end();
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL odd_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL odd_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
        end
        n_cmp++; if (fd_count !== exp_fd) begin n_mis++; $display("FAIL odd_frame_done: got %0d expected %0d", fd_count, exp_fd); end
    endtask

    task automatic test_oversize();
        int exp_fd;
        act_q.delete(); exp_q.delete(); fd_count = 0;
        frame_begin();
        for (int y = 0; y < SRC_V + 2; y++) drive_line(2 * (SRC_H + 6));
        exp_fd = model_capture ? 1 : 0;
        frame_end();
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL over_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL over_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
        end
        if (model_capture) begin
            n_cmp++;
            if (act_q.size() == 0 || act_q[act_q.size()-1][31:16] !== 16'(IMG_H * IMG_V - 1)) begin
                n_mis++;
                $display("FAIL over_last_addr: got %h expected %h", act_q.size() == 0 ? 16'hFFFF : act_q[act_q.size()-1][31:16], 16'(IMG_H * IMG_V - 1));
            end
        end
        n_cmp++; if (fd_count !== exp_fd) begin n_mis++; $display("FAIL over_frame_done: got %0d expected %0d", fd_count, exp_fd); end
    endtask

    task automatic test_reset_mid_frame();
        int exp_fd;
        act_q.delete(); exp_q.delete(); fd_count = 0;
        frame_begin();
        for (int y = 0; y < 20; y++) drive_line(2 * SRC_H);
        href = 1'b1;
        for (int i = 0; i < 7; i++) begin d = 8'($urandom); step(); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== 16'h0) begin n_mis++; $display("FAIL midrst_wr_addr: got %h expected 0000", wr_addr); end
        n_cmp++; if (wr_data !== 16'h0) begin n_mis++; $display("FAIL midrst_wr_data: got %h expected 0000", wr_data); end
        n_cmp++; if (frame_done !== 1'b0) begin n_mis++; $display("FAIL midrst_frame_done: got %b expected 0", frame_done); end
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        act_q.delete(); exp_q.delete(); fd_count = 0;
        for (int i = 0; i < 9; i++) begin d = 8'($urandom); step(); end
        href = 1'b0;
        step();
        for (int y = 21; y < SRC_V; y++) drive_line(2 * SRC_H);
        frame_end();
        n_cmp++; if (act_q.size() !== 0) begin n_mis++; $display("FAIL midrst_no_writes: got %0d expected 0", act_q.size()); end
        n_cmp++; if (fd_count !== 0) begin n_mis++; $display("FAIL midrst_no_frame_done: got %0d expected 0", fd_count); end
        act_q.delete(); exp_q.delete(); fd_count = 0;
        frame_begin();
        for (int y = 0; y < 8; y++) drive_line(2 * SRC_H);
        exp_fd = model_capture ? 1 : 0;
        frame_end();
        n_cmp++; if (act_q.size() == 0 || act_q[0][31:16] !== 16'h0) begin n_mis++; $display("FAIL midrst_first_addr: got %h expected 0000", act_q.size() == 0 ? 16'hFFFF : act_q[0][31:16]); end
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL midrst_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL midrst_write[%0d]: got %h expected %h", i, act_q[i], exp_q[i]); end
        end
        n_cmp++; if (fd_count !== exp_fd) begin n_mis++; $display("FAIL midrst_frame_done: got %0d expected %0d", fd_count, exp_fd); end
    endtask

    task automatic test_frame_skip();
        int exp_fd;
        rst_n = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        for (int f = 1; f <= 3; f++) begin
            act_q.delete(); exp_q.delete(); fd_count = 0;
            frame_begin();
            for (int y = 0; y < 8; y++) drive_line(64);
            exp_fd = model_capture ? 1 : 0;
            frame_end();
            n_cmp++; if (act_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL skip_count[f%0d]: got %0d expected %0d", f, act_q.size(), exp_q.size()); end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (act_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL skip_write[f%0d][%0d]: got %h expected %h", f, i, act_q[i], exp_q[i]); end
            end
            n_cmp++; if (fd_count !== exp_fd) begin n_mis++; $display("FAIL skip_frame_done[f%0d]: got %0d expected %0d", f, fd_count, exp_fd); end
        end
    endtask

    task automatic test_strobe_width();
        n_cmp++; if (dbl_wr !== 0) begin n_mis++; $display("FAIL strobe_width: got %0d back-to-back strobes expected 0", dbl_wr); end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_full_frame();
        test_odd_bytes();
        test_oversize();
        test_reset_mid_frame();
        test_frame_skip();
        test_strobe_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/camera_capture_writer.md
CAMERA_CAPTURE_WRITER -- requirements
Module: camera_capture_writer

Interface
REQ-001 SHALL have parameter IMAGE_SIZE_H, default 160, meaning destination pixels per line.
REQ-002 SHALL have parameter IMAGE_SIZE_V, default 120, meaning destination lines per frame.
REQ-003 SHALL have parameter SRC_SIZE_H, default 640, meaning sensor pixels per line.
REQ-004 SHALL have parameter SRC_SIZE_V, default 480, meaning sensor lines per frame.
REQ-005 SHALL have port clk, input, 1, meaning the sole clock (sensor pixel clock); all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port vsync, input, 1, meaning sensor frame sync, high during vertical blanking.
REQ-008 SHALL have port href, input, 1, meaning sensor line valid, high while bytes are valid.
REQ-009 SHALL have port d, input, 8, meaning sensor data byte, RGB565 high byte first.
REQ-010 SHALL have port wr_en, output, 1, meaning frame-buffer write strobe, one cycle per stored pixel.
REQ-011 SHALL have port wr_addr, output, 16, meaning frame-buffer write address, valid when wr_en=1.
REQ-012 SHALL have port wr_data, output, 16, meaning RGB565 pixel, valid when wr_en=1.
REQ-013 SHALL have port frame_done, output, 1, meaning one-cycle pulse at end of a captured frame.

Function
REQ-014 SHALL implement FSM states IDLE, SYNC, CAPTURE; IDLE->SYNC when vsync=1; SYNC->CAPTURE when vsync=0; CAPTURE->SYNC when vsync=1.
REQ-015 SHALL clear src_x, src_y, byte phase, and the write address on every SYNC->CAPTURE transition.
REQ-016 SHALL, in CAPTURE with href=1, latch d as high byte when phase=0 and form pixel {high, d} when phase=1, toggling phase each byte.
REQ-017 SHALL increment src_x (11 bits) on each completed pixel; SHALL ignore href and d outside CAPTURE.
REQ-018 SHALL, on href falling edge in CAPTURE, increment src_y (10 bits), clear src_x, and clear phase; an odd trailing byte SHALL be dropped.
REQ-019 SHALL store a completed pixel only when src_x[1:0]=0, src_y[1:0]=0, src_x<SRC_SIZE_H, src_y<SRC_SIZE_V (4:1 decimation each axis).
REQ-020 SHALL compute wr_addr = (src_y>>2)*IMAGE_SIZE_H + (src_x>>2), width 16, maximum 19199 at default parameters; writes with dst_x>=IMAGE_SIZE_H or dst_y>=IMAGE_SIZE_V SHALL be suppressed.
REQ-021 SHALL assert wr_en, wr_addr, wr_data registered, exactly one cycle after the clock edge sampling the low byte; wr_en SHALL be high for one cycle only.
REQ-022 SHALL pulse frame_done for one cycle on the CAPTURE->SYNC transition, never in IDLE or SYNC.
REQ-023 SHALL hold wr_addr and wr_data at their last values while wr_en=0.
REQ-024 SHALL ignore href pulses while vsync=1, even if simultaneous with the vsync rising edge.

Reset
REQ-025 SHALL on rst_n=0 force state IDLE, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, and all counters and phase to 0.
REQ-026 SHALL, after reset released mid-frame, write nothing until a vsync high-then-low sequence has been observed.

Configuration
REQ-027 SHALL, with CAPTURE_FRAME_SKIP_EN defined, toggle a frame parity bit on each SYNC->CAPTURE transition (first frame after reset captured) and suppress wr_en and frame_done for odd-parity frames.
REQ-028 SHALL, without CAPTURE_FRAME_SKIP_EN, capture every frame, with no parity logic present.

Verification
REQ-029 SHALL cover: reset, vsync 1->0, line0 bytes 0xF8,0x00 -> wr_en one cycle after second byte, wr_addr=0, wr_data=0xF800.
REQ-030 SHALL cover: full 640x480 frame with incrementing pixel values -> exactly 19200 writes, addresses 0..19199 in order, wr_data matches every 4th pixel of every 4th line.
REQ-031 SHALL cover: line with 5 bytes -> 2 pixels counted, trailing byte dropped, next line starts with phase=0.
REQ-032 SHALL cover: 700-pixel line, 500-line frame -> no writes beyond src_x 639 or src_y 479, last wr_addr=19199.
REQ-033 SHALL cover: rst_n low at line 200 -> outputs 0 immediately; no wr_en until next vsync 1->0; following frame starts at wr_addr=0.
REQ-034 SHALL cover: CAPTURE_FRAME_SKIP_EN defined, three frames -> frames 1 and 3 write and pulse frame_done, frame 2 produces neither.
